button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; consecutive stable cycles needed to accept a raw change (10 ms at 50 MHz).
REQ-002 Parameter CHORD_WINDOW, default 2500000; maximum cycles between the two presses of a chord.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_a_n  input  1  raw push-button A, asynchronous, active-low.
REQ-006 btn_b_n  input  1  raw push-button B, asynchronous, active-low.
REQ-007 a_lvl / b_lvl  output  1 each  debounced pressed level, active-high.
REQ-008 a_pulse / b_pulse  output  1 each  one-cycle strobe on each debounced press.
REQ-009 chord_pulse  output  1  one-cycle strobe when A and B are pressed within CHORD_WINDOW.
REQ-010 chord_lvl  output  1  high while an accepted chord is held.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer, then be inverted to active-high.
REQ-012 Per channel, a counter SHALL increment while the synchronized value differs from the debounced level, and clear to 0 whenever they match.
REQ-013 The debounced level SHALL take the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES-1; the counter then clears.
REQ-014 A raw change held stable SHALL appear on x_lvl exactly 2+DEBOUNCE_CYCLES cycles after the first clock edge that samples it.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change x_lvl.
REQ-016 x_pulse SHALL be high exactly in the first cycle x_lvl is high; releases produce no pulse.
REQ-017 Chord FSM states: IDLE, WAIT_B, WAIT_A, CHORD.
REQ-018 IDLE: a_pulse&b_pulse -> CHORD; a_pulse only -> WAIT_B; b_pulse only -> WAIT_A. A WAIT state loads the window counter with 0.
REQ-019 WAIT_B: b_pulse -> CHORD; a_lvl low -> IDLE; window counter reaching CHORD_WINDOW-1 -> IDLE; otherwise increment. WAIT_A is symmetric with A and B swapped.
REQ-020 Within a WAIT state, partner pulse and window expiry in the same cycle SHALL resolve to CHORD.
REQ-021 CHORD: stay until a_lvl and b_lvl are both low, then go to IDLE. Further pulses in CHORD are ignored.
REQ-022 chord_pulse SHALL be registered and high for exactly one cycle, the cycle after the qualifying press pulse(s), i.e. the first cycle in CHORD.
REQ-023 chord_lvl SHALL be high in every cycle the FSM is in CHORD.
REQ-024 a_pulse and b_pulse SHALL still be emitted during chord recognition; chord outputs are additional.

Reset
REQ-025 Asserting reset (low) SHALL immediately clear synchronizers, counters, levels, pulses and chord outputs to 0, and put the FSM in IDLE, including mid-debounce or mid-chord.
REQ-026 After reset deasserts with a button already held, the press SHALL be detected as a normal press after 2+DEBOUNCE_CYCLES cycles.

Structure
REQ-027 Package ktne_pkg SHALL hold the chord-state enum typedef and the default DEBOUNCE_CYCLES and CHORD_WINDOW constants.
REQ-028 Sub-module debounce_ch (synchronizer, counter, level, pulse) SHALL be instantiated once per button.
REQ-029 Counter widths SHALL be $clog2 of the respective parameter and SHALL never wrap.

Verification (DEBOUNCE_CYCLES=4, CHORD_WINDOW=8)
REQ-030 Bench SHALL cover: btn_a_n low from cycle 0 -> a_lvl high and a_pulse one cycle at cycle 6; b outputs stay 0.
REQ-031 Bench SHALL cover: btn_a_n low for 3 cycles, then high -> a_lvl and a_pulse never assert.
REQ-032 Bench SHALL cover: A pressed, B pressed 5 cycles later -> a_pulse, b_pulse, then chord_pulse one cycle after b_pulse; chord_lvl high until both released.
REQ-033 Bench SHALL cover: A pressed, B pressed 12 cycles later -> FSM returns to IDLE; B starts WAIT_A; no chord_pulse.
REQ-034 Bench SHALL cover: both buttons pressed on the same cycle -> a_pulse and b_pulse coincide; chord_pulse follows in the next cycle.
REQ-035 Bench SHALL cover: reset asserted while in CHORD -> all outputs 0 immediately; FSM is IDLE after release.

Source files
------------

// File: rtl/ktne_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ktne_pkg : chord-state type and default timing for button inputs   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package ktne_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_CHORD_WINDOW    = 2500000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    WAIT_A = 2'd2,
    CHORD  = 2'd3
  } chord_state_t;

  // Width of a counter that only ever holds 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_ch : synchronizer, stability counter, level and press pulse|
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module debounce_ch
  import ktne_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic lvl,
  output logic pulse
);

  localparam int unsigned   CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_ff;
  logic [CNT_W-1:0] cnt;

  // Inversion sits ahead of the flops so a cleared synchronizer means "released".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= '0;
      cnt     <= '0;
      lvl     <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], ~btn_n};
      pulse   <= 1'b0;
      if (sync_ff[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        lvl   <= sync_ff[1];
        pulse <= sync_ff[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | button_conditioner : two debounced buttons plus A+B chord detection|
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module button_conditioner
  import ktne_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CHORD_WINDOW    = DEFAULT_CHORD_WINDOW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_n,
  input  logic btn_b_n,
  output logic a_lvl,
  output logic b_lvl,
  output logic a_pulse,
  output logic b_pulse,
  output logic chord_pulse,
  output logic chord_lvl
);

  localparam int unsigned      WIN_W    = cnt_width(CHORD_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHORD_WINDOW - 1);

  chord_state_t     state, state_nxt;
  logic [WIN_W-1:0] win, win_nxt;

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_a (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_a_n),
    .lvl   (a_lvl),
    .pulse (a_pulse)
  );

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_b (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_b_n),
    .lvl   (b_lvl),
    .pulse (b_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      win         <= '0;
      chord_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      win         <= win_nxt;
      chord_pulse <= (state != CHORD) && (state_nxt == CHORD);
    end
  end

  // Partner pulse is tested first so it wins over release and window expiry.
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    case (state)
      IDLE: begin
        win_nxt = '0;
        if (a_pulse && b_pulse) state_nxt = CHORD;
        else if (a_pulse)       state_nxt = WAIT_B;
        else if (b_pulse)       state_nxt = WAIT_A;
      end
      WAIT_B: begin
        if (b_pulse)              state_nxt = CHORD;
        else if (!a_lvl)          state_nxt = IDLE;
        else if (win == WIN_LAST) state_nxt = IDLE;
        else                      win_nxt   = win + WIN_W'(1);
      end
      WAIT_A: begin
        if (a_pulse)              state_nxt = CHORD;
        else if (!b_lvl)          state_nxt = IDLE;
        else if (win == WIN_LAST) state_nxt = IDLE;
        else                      win_nxt   = win + WIN_W'(1);
      end
      CHORD: begin
        if (!a_lvl && !b_lvl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign chord_lvl = (state == CHORD);

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_button_conditioner : directed checks, DEBOUNCE=4, WINDOW=8      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_button_conditioner;
  import ktne_pkg::*;

  logic clk;
  logic reset;
  logic btn_a_n;
  logic btn_b_n;
  logic a_lvl, b_lvl, a_pulse, b_pulse, chord_pulse, chord_lvl;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CHORD_WINDOW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_a_n     (btn_a_n),
    .btn_b_n     (btn_b_n),
    .a_lvl       (a_lvl),
    .b_lvl       (b_lvl),
    .a_pulse     (a_pulse),
    .b_pulse     (b_pulse),
    .chord_pulse (chord_pulse),
    .chord_lvl   (chord_lvl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic eal, input logic ebl,
                            input logic eap, input logic ebp, input logic ecp, input logic ecl);
    check({tag, ".a_lvl"},       {7'b0, a_lvl},       {7'b0, eal});
    check({tag, ".b_lvl"},       {7'b0, b_lvl},       {7'b0, ebl});
    check({tag, ".a_pulse"},     {7'b0, a_pulse},     {7'b0, eap});
    check({tag, ".b_pulse"},     {7'b0, b_pulse},     {7'b0, ebp});
    check({tag, ".chord_pulse"}, {7'b0, chord_pulse}, {7'b0, ecp});
    check({tag, ".chord_lvl"},   {7'b0, chord_lvl},   {7'b0, ecl});
  endtask

  task automatic check_state(input string tag, input chord_state_t exp);
    check({tag, ".state"}, {6'b0, dut.state}, {6'b0, exp});
  endtask

  // Buttons released, reset pulsed, released on a falling edge; edge 1 is the next rise.
  task automatic start_run();
    reset   = 1'b0;
    btn_a_n = 1'b1;
    btn_b_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b0;
    btn_a_n = 1'b1;
    btn_b_n = 1'b1;
    #2;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    check_state("reset", IDLE);

    // A held from the first edge: level and pulse on edge 6
    start_run();
    btn_a_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_outs($sformatf("press@%0d", k), k >= 6, 0, k == 6, 0, 0, 0);
    end

    // Three-sample glitch is rejected
    start_run();
    btn_a_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) btn_a_n = 1'b1;
      check_outs($sformatf("glitch@%0d", k), 0, 0, 0, 0, 0, 0);
    end

    // B five cycles after A: chord, then held until both released
    start_run();
    btn_a_n = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      tick();
      if (k == 5)  btn_b_n = 1'b0;
      if (k == 20) btn_a_n = 1'b1;
      if (k == 28) btn_b_n = 1'b1;
      check_outs($sformatf("chord@%0d", k), k >= 6 && k < 26, k >= 11 && k < 34,
                 k == 6, k == 11, k == 12, k >= 12 && k < 35);
    end

    // B twelve cycles after A: window expires, B opens WAIT_A
    start_run();
    btn_a_n = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 12) btn_b_n = 1'b0;
      check_outs($sformatf("late@%0d", k), k >= 6, k >= 18, k == 6, k == 18, 0, 0);
      check_state($sformatf("late@%0d", k),
                  (k < 7) ? IDLE : (k < 15) ? WAIT_B : (k < 19) ? IDLE : WAIT_A);
    end

    // B pulse on the last window cycle still makes a chord
    start_run();
    btn_a_n = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 8) btn_b_n = 1'b0;
      check_outs($sformatf("edge@%0d", k), k >= 6, k >= 14, k == 6, k == 14, k == 15, k >= 15);
    end

    // Simultaneous press, then reset while in CHORD
    start_run();
    btn_a_n = 1'b0;
    btn_b_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_outs($sformatf("both@%0d", k), k >= 6, k >= 6, k == 6, k == 6, k == 7, k >= 7);
    end
    reset = 1'b0;
    #1;
    check_outs("midrst", 0, 0, 0, 0, 0, 0);
    check_state("midrst", IDLE);
    @(negedge clk);
    reset = 1'b1;
    check_state("rel@0", IDLE);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_outs($sformatf("rel@%0d", k), k >= 6, k >= 6, k == 6, k == 6, k == 7, k >= 7);
      check_state($sformatf("rel@%0d", k), (k >= 7) ? CHORD : IDLE);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
